// File: rtl/id_issue_stage.sv
// Decode/issue stage of a 5-stage MIPS32 pipeline: decodes a logic/shift subset, resolves
// bypassed operands, and owns the ID/EX register with a valid/ready handshake and load-use interlock.
module id_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_pc,
    input  logic [31:0]               in_inst,
    output logic                      re1,
    output logic                      re2,
    output logic [4:0]                readAddr1,
    output logic [4:0]                readAddr2,
    input  logic [DATA_W-1:0]         regData1,
    input  logic [DATA_W-1:0]         regData2,
    input  logic [NUM_FWD-1:0]        fwd_wReg,
    input  logic [5*NUM_FWD-1:0]      fwd_wAddr,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_wData,
    input  logic                      ex_load,
    input  logic [4:0]                ex_load_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [7:0]                aluOp,
    output logic [DATA_W-1:0]         opNum1,
    output logic [DATA_W-1:0]         opNum2,
    output logic                      writeReg,
    output logic [4:0]                writeAddr,
    output logic                      illegal,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [7:0] EXE_NOP_OP = 8'h00;
    localparam logic [7:0] EXE_OR_OP  = 8'h25;
    localparam logic [7:0] EXE_AND_OP = 8'h24;
    localparam logic [7:0] EXE_XOR_OP = 8'h26;
    localparam logic [7:0] EXE_NOR_OP = 8'h27;
    localparam logic [7:0] EXE_SLL_OP = 8'h7C;
    localparam logic [7:0] EXE_SRL_OP = 8'h02;
    localparam logic [7:0] EXE_SRA_OP = 8'h03;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    assign opcode = in_inst[31:26];
    assign rs     = in_inst[25:21];
    assign rt     = in_inst[20:16];
    assign rd     = in_inst[15:11];
    assign shamt  = in_inst[10:6];
    assign funct  = in_inst[5:0];
    assign imm16  = in_inst[15:0];

    logic              dec_re1, dec_re2, dec_wreg, dec_illegal;
    logic [4:0]        dec_waddr;
    logic [7:0]        dec_op;
    logic [DATA_W-1:0] dec_imm1, dec_imm2;

    always_comb begin
        dec_op      = EXE_NOP_OP;
        dec_re1     = 1'b0;
        dec_re2     = 1'b0;
        dec_wreg    = 1'b0;
        dec_waddr   = 5'd0;
        dec_imm1    = '0;
        dec_imm2    = '0;
        dec_illegal = 1'b0;
        if (in_inst != 32'd0) begin
            unique case (opcode)
                OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
                    dec_re1   = 1'b1;
                    dec_wreg  = 1'b1;
                    dec_waddr = rt;
                    dec_imm2  = DATA_W'(imm16);
                    unique case (opcode)
                        OP_ANDI: dec_op = EXE_AND_OP;
                        OP_XORI: dec_op = EXE_XOR_OP;
                        OP_LUI: begin
                            dec_op   = EXE_OR_OP;
                            dec_imm2 = DATA_W'({imm16, 16'h0000});
                        end
                        default: dec_op = EXE_OR_OP;
                    endcase
                end
                OP_SPECIAL: begin
                    // Register-register forms need shamt=0; immediate shifts need rs=0.
                    if (shamt == 5'd0 && (funct == 6'b100101 || funct == 6'b100100 ||
                        funct == 6'b100110 || funct == 6'b100111 || funct == 6'b000100 ||
                        funct == 6'b000110 || funct == 6'b000111)) begin
                        dec_re1   = 1'b1;
                        dec_re2   = 1'b1;
                        dec_wreg  = 1'b1;
                        dec_waddr = rd;
                        unique case (funct)
                            6'b100101: dec_op = EXE_OR_OP;
                            6'b100100: dec_op = EXE_AND_OP;
                            6'b100110: dec_op = EXE_XOR_OP;
                            6'b100111: dec_op = EXE_NOR_OP;
                            6'b000100: dec_op = EXE_SLL_OP;
                            6'b000110: dec_op = EXE_SRL_OP;
                            default:   dec_op = EXE_SRA_OP;
                        endcase
                    end else if (rs == 5'd0 && (funct == 6'b000000 || funct == 6'b000010 ||
                                 funct == 6'b000011)) begin
                        dec_re2   = 1'b1;
                        dec_wreg  = 1'b1;
                        dec_waddr = rd;
                        dec_imm1  = DATA_W'(shamt);
                        unique case (funct)
                            6'b000000: dec_op = EXE_SLL_OP;
                            6'b000010: dec_op = EXE_SRL_OP;
                            default:   dec_op = EXE_SRA_OP;
                        endcase
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign re1       = dec_re1;
    assign re2       = dec_re2;
    assign readAddr1 = rs;
    assign readAddr2 = rt;

    // $0 wins over any bypass; otherwise the lowest-index (youngest) matching source wins.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [4:0]                addr,
        input logic [DATA_W-1:0]         rdata,
        input logic [NUM_FWD-1:0]        wreg,
        input logic [5*NUM_FWD-1:0]      waddr,
        input logic [DATA_W*NUM_FWD-1:0] wdata
    );
        logic [DATA_W-1:0] r;
        r = rdata;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (wreg[i] && waddr[5*i +: 5] == addr) r = wdata[DATA_W*i +: DATA_W];
        end
        if (addr == 5'd0) r = '0;
        return r;
    endfunction

    logic [DATA_W-1:0] src1, src2;
    logic              hazard, adv, accept;

    assign src1 = dec_re1 ? resolve(rs, regData1, fwd_wReg, fwd_wAddr, fwd_wData) : dec_imm1;
    assign src2 = dec_re2 ? resolve(rt, regData2, fwd_wReg, fwd_wAddr, fwd_wData) : dec_imm2;

    assign hazard = in_valid && ex_load && (ex_load_addr != 5'd0) &&
                    ((dec_re1 && rs == ex_load_addr) || (dec_re2 && rt == ex_load_addr));

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_pc_q, out_pc_d;
    logic [7:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] op_num1_q, op_num1_d, op_num2_q, op_num2_d;
    logic              write_reg_q, write_reg_d;
    logic [4:0]        write_addr_q, write_addr_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        alu_op_d     = alu_op_q;
        op_num1_d    = op_num1_q;
        op_num2_d    = op_num2_q;
        write_reg_d  = write_reg_q;
        write_addr_d = write_addr_q;
        illegal_d    = illegal_q;
        if (adv) begin
            out_valid_d = accept;
            if (accept) begin
                out_pc_d     = in_pc;
                alu_op_d     = dec_op;
                op_num1_d    = src1;
                op_num2_d    = src2;
                write_reg_d  = dec_wreg;
                write_addr_d = dec_waddr;
                illegal_d    = dec_illegal;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'd0;
            alu_op_q     <= EXE_NOP_OP;
            op_num1_q    <= '0;
            op_num2_q    <= '0;
            write_reg_q  <= 1'b0;
            write_addr_q <= 5'd0;
            illegal_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            alu_op_q     <= alu_op_d;
            op_num1_q    <= op_num1_d;
            op_num2_q    <= op_num2_d;
            write_reg_q  <= write_reg_d;
            write_addr_q <= write_addr_d;
            illegal_q    <= illegal_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign aluOp     = alu_op_q;
    assign opNum1    = op_num1_q;
    assign opNum2    = op_num2_q;
    assign writeReg  = write_reg_q;
    assign writeAddr = write_addr_q;
    assign illegal   = illegal_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: expected ID/EX contents are queued on accept and
// compared when EX consumes the register.
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst;
    logic        re1, re2;
    logic [4:0]  readAddr1, readAddr2;
    logic [31:0] regData1, regData2;
    logic [1:0]  fwd_wReg;
    logic [9:0]  fwd_wAddr;
    logic [63:0] fwd_wData;
    logic        ex_load;
    logic [4:0]  ex_load_addr;
    logic        out_valid, out_ready;
    logic [31:0] out_pc;
    logic [7:0]  aluOp;
    logic [31:0] opNum1, opNum2;
    logic        writeReg;
    logic [4:0]  writeAddr;
    logic        illegal;
    logic [15:0] stall_cnt;

    id_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .re1(re1), .re2(re2), .readAddr1(readAddr1), .readAddr2(readAddr2),
        .regData1(regData1), .regData2(regData2),
        .fwd_wReg(fwd_wReg), .fwd_wAddr(fwd_wAddr), .fwd_wData(fwd_wData),
        .ex_load(ex_load), .ex_load_addr(ex_load_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .aluOp(aluOp),
        .opNum1(opNum1), .opNum2(opNum2), .writeReg(writeReg), .writeAddr(writeAddr),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] NOP = 8'h00, OR = 8'h25, XOR = 8'h26, AND = 8'h24, SLL = 8'h7C;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wr;
        logic [4:0]  wa;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t obs, e;
        obs = '{pc: out_pc, op: aluOp, a: opNum1, b: opNum2, wr: writeReg, wa: writeAddr, ill: illegal};
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL sb_empty observed=%h expected=queued_entry", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL out_pc%0h observed=%h expected=%h", e.pc, obs, e);
            end
        end
    endtask

    task automatic tick();
        #1;
        if (out_valid && out_ready) check_out();
        if (in_valid && in_ready) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] pc, input logic [31:0] inst, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic wr,
                       input logic [4:0] wa, input logic ill);
        in_pc    = pc;
        in_inst  = inst;
        in_valid = 1'b1;
        pend     = '{pc: pc, op: op, a: a, b: b, wr: wr, wa: wa, ill: ill};
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        regData1 = '0; regData2 = '0; fwd_wReg = '0; fwd_wAddr = '0; fwd_wData = '0;
        ex_load = 1'b0; ex_load_addr = '0; out_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_aluop", 32'(aluOp), 32'(NOP));
        chk("rst_op1", opNum1, 32'd0);
        chk("rst_op2", opNum2, 32'd0);
        chk("rst_wr", 32'(writeReg), 32'd0);
        chk("rst_wa", 32'(writeAddr), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // ori $1,$0,0x1234 ; $0 must read as zero despite regData1
        regData1 = 32'hDEAD;
        drv(32'h100, 32'h34011234, OR, 32'h0, 32'h1234, 1'b1, 5'd1, 1'b0);
        tick();
        chk("ori_latency", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();

        // or $3,$1,$2 with both bypasses hitting $1, then only the older one
        fwd_wReg = 2'b11; fwd_wAddr = {5'd1, 5'd1}; fwd_wData = {32'hB, 32'hA};
        regData1 = 32'hC; regData2 = 32'h22;
        drv(32'h104, 32'h00221825, OR, 32'hA, 32'h22, 1'b1, 5'd3, 1'b0);
        #1;
        chk("or_re", 32'({re1, re2}), 32'd3);
        chk("or_ra1", 32'(readAddr1), 32'd1);
        chk("or_ra2", 32'(readAddr2), 32'd2);
        tick();
        fwd_wReg = 2'b10;
        drv(32'h108, 32'h00221825, OR, 32'hB, 32'h22, 1'b1, 5'd3, 1'b0);
        tick();
        in_valid = 1'b0; fwd_wReg = 2'b00;
        tick();

        // sll $4,$2,5 behind a load to $2
        regData2 = 32'h77; ex_load = 1'b1; ex_load_addr = 5'd2;
        drv(32'h10C, 32'h00022140, SLL, 32'd5, 32'h77, 1'b1, 5'd4, 1'b0);
        #1;
        chk("hz_ready", 32'(in_ready), 32'd0);
        tick();
        chk("hz_bubble", 32'(out_valid), 32'd0);
        chk("hz_stall", 32'(stall_cnt), 32'd1);
        ex_load = 1'b0;
        tick();
        chk("hz_issued", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();

        // backpressure: xori held for 3 cycles while andi waits
        drv(32'h400, 32'h380500FF, XOR, 32'h0, 32'hFF, 1'b1, 5'd5, 1'b0);
        tick();
        out_ready = 1'b0;
        drv(32'h404, 32'h3006F0F0, AND, 32'h0, 32'hF0F0, 1'b1, 5'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_pc", out_pc, 32'h400);
            chk("bp_op2", opNum2, 32'hFF);
            chk("bp_valid", 32'(out_valid), 32'd1);
            tick();
        end
        chk("bp_stall", 32'(stall_cnt), 32'd4);
        out_ready = 1'b1;
        tick();
        chk("bp_next_pc", out_pc, 32'h404);
        in_valid = 1'b0;
        tick();

        // illegal word, bypass write to $0, lui, srav with nonzero shamt
        drv(32'h500, 32'hFC000000, NOP, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
        tick();
        fwd_wReg = 2'b01; fwd_wAddr = {5'd9, 5'd0}; fwd_wData = {32'h0, 32'hFF};
        regData1 = 32'h55; regData2 = 32'h33;
        drv(32'h504, 32'h00023825, OR, 32'h0, 32'h33, 1'b1, 5'd7, 1'b0);
        tick();
        fwd_wReg = 2'b00;
        drv(32'h508, 32'h3C08ABCD, OR, 32'h0, 32'hABCD0000, 1'b1, 5'd8, 1'b0);
        tick();
        drv(32'h50C, 32'h00221847, NOP, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();

        // asynchronous reset with an instruction in the ID/EX register
        drv(32'h600, 32'h34090055, OR, 32'h0, 32'h55, 1'b1, 5'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_aluop", 32'(aluOp), 32'(NOP));
        chk("mrst_op2", opNum2, 32'd0);
        chk("mrst_pc", out_pc, 32'd0);
        chk("mrst_wr", 32'(writeReg), 32'd0);
        chk("mrst_wa", 32'(writeAddr), 32'd0);
        chk("mrst_stall", 32'(stall_cnt), 32'd0);
        sb.delete();
        #3;
        rst = 1'b1;
        drv(32'h700, 32'h34011234, OR, 32'h0, 32'h1234, 1'b1, 5'd1, 1'b0);
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
